// File: rtl/mul8_arbiter.sv
// Two-requester round-robin arbiter feeding one shared signed 8x8 multiplier through a two-stage pipeline.
// Optional per-requester saturating grant counters are enabled by defining MUL8_ARB_STATS_EN.

module SignedMultiplier8x8 (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] p
);
    assign p = a * b;
endmodule

module mul8_arbiter #(
    parameter int unsigned RR_RESET_PTR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in0_valid,
    output logic        in0_ready,
    input  logic [7:0]  in0_a,
    input  logic [7:0]  in0_b,
    input  logic        in1_valid,
    output logic        in1_ready,
    input  logic [7:0]  in1_a,
    input  logic [7:0]  in1_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic        out_id
`ifdef MUL8_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);

    logic              s1_valid;
    logic [7:0]        s1_a;
    logic [7:0]        s1_b;
    logic              s1_id;
    logic              last_ptr;
    logic              s2_load;
    logic              s1_accept;
    logic              grant0;
    logic              grant1;
    logic signed [15:0] mul_p;

    SignedMultiplier8x8 u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (mul_p)
    );

    assign s2_load   = !out_valid || out_ready;
    assign s1_accept = !s1_valid || s2_load;

    // Grants are masked by reset so no request is acknowledged while the pipeline is being flushed.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && s1_accept) begin
            if (in0_valid && in1_valid) begin
                grant0 = last_ptr;
                grant1 = !last_ptr;
            end else begin
                grant0 = in0_valid;
                grant1 = in1_valid;
            end
        end
    end

    assign in0_ready = grant0;
    assign in1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_id    <= 1'b0;
            last_ptr  <= 1'(RR_RESET_PTR);
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_prod <= mul_p;
                    out_id   <= s1_id;
                end
            end
            if (s1_accept) begin
                s1_valid <= grant0 || grant1;
                if (grant0 || grant1) begin
                    s1_a     <= grant1 ? in1_a : in0_a;
                    s1_b     <= grant1 ? in1_b : in0_b;
                    s1_id    <= grant1;
                    last_ptr <= grant1;
                end
            end
        end
    end

`ifdef MUL8_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul8_arbiter.sv
// Self-checking bench for mul8_arbiter: directed vector table, corner-case sequences and a randomized run
// checked against an in-order queue model of the arbitrated multiplier.

module tb_mul8_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in0_valid, in1_valid, out_ready;
    logic        in0_ready, in1_ready, out_valid, out_id;
    logic [7:0]  in0_a, in0_b, in1_a, in1_b;
    logic [15:0] out_prod;
`ifdef MUL8_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    mul8_arbiter #(.RR_RESET_PTR(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_a     (in0_a),
        .in0_b     (in0_b),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_a     (in1_a),
        .in1_b     (in1_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_id    (out_id)
`ifdef MUL8_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    typedef struct packed {
        logic [15:0] prod;
        logic        id;
        logic        st2;
    } item_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        id;
        logic [15:0] prod;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    item_t mq[$];
    bit    m_ptr;
    bit    eg0, eg1;
    int    popped = 0;
    int    glog[$];
    int    olog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        x = $signed(a);
        y = $signed(b);
        return 16'(x * y);
    endfunction

    // One clock cycle: compare DUT against the model, cross the edge, advance the model.
    task automatic tick();
        bit    e_ov, s2_load, s1_has, can;
        item_t it, tl;
        #1;
        e_ov    = mq.size() > 0 && mq[0].st2;
        s2_load = !e_ov || out_ready;
        s1_has  = mq.size() > 0 && !mq[mq.size()-1].st2;
        can     = !s1_has || s2_load;
        eg0 = rst_n && can && in0_valid && (!in1_valid || m_ptr == 1'b1);
        eg1 = rst_n && can && in1_valid && (!in0_valid || m_ptr == 1'b0);
        chk("in0_ready", {31'd0, in0_ready}, {31'd0, eg0});
        chk("in1_ready", {31'd0, in1_ready}, {31'd0, eg1});
        chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
        if (e_ov) begin
            chk("out_prod", {16'd0, out_prod}, {16'd0, mq[0].prod});
            chk("out_id", {31'd0, out_id}, {31'd0, mq[0].id});
        end
        if (rst_n && (in0_ready || in1_ready)) glog.push_back(int'(in1_ready));
        if (rst_n && out_valid && out_ready) olog.push_back(int'(out_id));
        it.id   = eg1;
        it.st2  = 1'b0;
        it.prod = eg1 ? ref_mul(in1_a, in1_b) : ref_mul(in0_a, in0_b);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_ptr = 1'b0;
        end else begin
            if (e_ov && out_ready) begin
                void'(mq.pop_front());
                popped++;
            end
            if (s2_load && s1_has) begin
                tl = mq[mq.size()-1];
                tl.st2 = 1'b1;
                mq[mq.size()-1] = tl;
            end
            if (eg0 || eg1) begin
                mq.push_back(it);
                m_ptr = eg1;
            end
        end
        #1;
    endtask

    task automatic idle();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rnd8();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'hFF;
            3: return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    vec_t vt[8];

    initial begin
        int  base, sent, stalls, pop0;
        bit  rv0, rv1;
        logic [7:0] ops[6];

        vt[0] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vt[1] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vt[2] = '{8'h00, 8'hFB, 1'b1, 16'h0000};
        vt[3] = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};
        vt[4] = '{8'hFF, 8'h01, 1'b0, 16'hFFFF};
        vt[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vt[6] = '{8'h7F, 8'h80, 1'b0, 16'hC080};
        vt[7] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};

        rst_n = 1'b0;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        in0_a = 8'd3; in0_b = 8'd4; in1_a = 8'd5; in1_b = 8'd6;
        m_ptr = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_prod", {16'd0, out_prod}, 32'd0);
        chk("reset_out_id", {31'd0, out_id}, 32'd0);
        chk("reset_readys", {30'd0, in1_ready, in0_ready}, 32'd0);
`ifdef MUL8_ARB_STATS_EN
        chk("reset_cnt0", {16'd0, grant_cnt0}, 32'd0);
        chk("reset_cnt1", {16'd0, grant_cnt1}, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        idle();

        // Directed single-requester products with latency check
        for (int i = 0; i < 8; i++) begin
            in0_valid = !vt[i].id; in1_valid = vt[i].id;
            in0_a = vt[i].a; in0_b = vt[i].b; in1_a = vt[i].a; in1_b = vt[i].b;
            tick();
            idle();
            chk("lat_n_out_valid", {31'd0, out_valid}, 32'd0);
            tick();
            chk("vec_out_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_out_prod", {16'd0, out_prod}, {16'd0, vt[i].prod});
            chk("vec_out_id", {31'd0, out_id}, {31'd0, vt[i].id});
            tick();
        end

        // Round-robin with both requesters valid from reset
        do_reset();
        glog.delete(); olog.delete();
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_a = 8'd2; in0_b = 8'd9; in1_a = 8'hF0; in1_b = 8'd3;
        for (int i = 0; i < 8; i++) tick();
        idle();
        tick(); tick(); tick();
        chk("rr_grants", glog.size(), 8);
        chk("rr_outs", olog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size() && i < olog.size(); i++) begin
            chk("rr_grant_order", glog[i], (i % 2 == 0) ? 1 : 0);
            chk("rr_out_id_order", olog[i], (i % 2 == 0) ? 1 : 0);
        end
`ifdef MUL8_ARB_STATS_EN
        chk("rr_cnt0", {16'd0, grant_cnt0}, 32'd4);
        chk("rr_cnt1", {16'd0, grant_cnt1}, 32'd4);
`endif

        // Six requests with a five-cycle output stall mid-stream
        for (int i = 0; i < 6; i++) ops[i] = 8'(8'h80 + 8'(i * 37));
        sent = 0; stalls = 0; pop0 = popped;
        for (int c = 0; c < 25; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            in0_valid = sent < 6;
            in0_a = sent < 6 ? ops[sent] : 8'd0;
            in0_b = 8'h81;
            #1;
            if (in0_valid && !in0_ready) stalls++;
            tick();
            if (eg0) sent++;
        end
        idle(); out_ready = 1'b1;
        chk("stall_sent", sent, 6);
        chk("stall_popped", popped - pop0, 6);
        chk("stall_ready_dropped", {31'd0, stalls > 0}, 32'd1);

        // Reset with S1 and S2 both full
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_a = 8'd11; in0_b = 8'd13;
        tick();
        in0_a = 8'd17;
        tick();
        idle();
        pop0 = popped;
        rst_n = 1'b0;
        #1;
        chk("rst_readys_low", {30'd0, in1_ready, in0_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_a = 8'd1; in0_b = 8'd1; in1_a = 8'd2; in1_b = 8'd2;
        #1;
        chk("rst_ptr_grant1", {30'd0, in1_ready, in0_ready}, 32'd2);
        tick();
        idle();
        tick(); tick(); tick();
        chk("rst_no_stale_out", popped - pop0, 1);

        // Randomized traffic against the model
        rv0 = 1'b0; rv1 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!rv0) begin rv0 = ($urandom_range(0, 2) != 0); in0_a = rnd8(); in0_b = rnd8(); end
            if (!rv1) begin rv1 = ($urandom_range(0, 2) != 0); in1_a = rnd8(); in1_b = rnd8(); end
            in0_valid = rv0; in1_valid = rv1;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (eg0) rv0 = 1'b0;
            if (eg1) rv1 = 1'b0;
        end
        idle(); out_ready = 1'b1;
        tick(); tick(); tick();
        chk("rand_drained", mq.size(), 0);

`ifdef MUL8_ARB_STATS_EN
        // Counter saturation
        do_reset();
        in0_valid = 1'b1; in0_a = 8'd3; in0_b = 8'd3;
        for (int i = 0; i < 65537; i++) tick();
        idle();
        tick();
        chk("sat_cnt0", {16'd0, grant_cnt0}, 32'h0000FFFF);
        chk("sat_cnt1", {16'd0, grant_cnt1}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
